// File: rtl/bp_me_accel_wr_sink.sv
// ============================================================================
// bp_me_accel_wr_sink
// ----------------------------------------------------------------------------
// Responder for streamed mem_fwd uncached writes into a local scratchpad.
//
// A message is one header held stable across N data beats, where
// N = max(1, (8 << size) / fill_width). Beat k of a uc_wr message is stored
// at word ((addr >> log2(fill_bytes)) + k) mod els_p. Any other message type
// is drained beat by beat without touching the scratchpad. Every message,
// good or bad, gets exactly one response that echoes the latched header
// and carries all-zero data. New beats are refused while a response is
// pending.
//
// Ports
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   mem_fwd_header_i/data_i inbound write stream (valid/ready_and)
//   mem_fwd_v_i, mem_fwd_ready_and_o
//   mem_rev_header_o/data_o response stream (valid/ready_and)
//   mem_rev_v_o, mem_rev_ready_and_i
//   rd_addr_i, rd_v_i       core-side read request
//   rd_data_o, rd_v_o       read data, one cycle after the request
//   wr_beats_o, bad_msgs_o  saturating perf counters
//
// Configuration
//   BP_ME_ACCEL_WR_SINK_PERF_EN  when defined, wr_beats_o counts stored beats
//                                and bad_msgs_o counts rejected messages.
//                                When undefined both ports are tied to 0 and
//                                no counter flops exist.
// ============================================================================

package bp_me_accel_wr_sink_pkg;

  typedef enum logic [3:0] {
    e_bp_default_cfg   = 4'd0,
    e_bp_wide_fill_cfg = 4'd1
  } bp_params_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_pre   = 4'd4,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  localparam int paddr_width_gp   = 40;
  localparam int payload_width_gp = 16;

  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    logic [2:0]                  size;
    logic [paddr_width_gp-1:0]   addr;
    logic [3:0]                  subop;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_header_s;

  // Fill (beat) width in bits selected by the configuration.
  function automatic int bedrock_fill_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg:   return 64;
      e_bp_wide_fill_cfg: return 128;
      default:            return 64;
    endcase
  endfunction

endpackage

module bp_me_accel_wr_sink
  import bp_me_accel_wr_sink_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int els_p = 256,
  localparam int bedrock_fill_width_p    = bedrock_fill_width(bp_params_p),
  localparam int mem_fwd_header_width_lp = $bits(bp_bedrock_mem_header_s),
  localparam int mem_rev_header_width_lp = $bits(bp_bedrock_mem_header_s),
  localparam int addr_width_lp           = $clog2(els_p)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,

  input  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i,
  input  logic [bedrock_fill_width_p-1:0]    mem_fwd_data_i,
  input  logic                               mem_fwd_v_i,
  output logic                               mem_fwd_ready_and_o,

  output logic [mem_rev_header_width_lp-1:0] mem_rev_header_o,
  output logic [bedrock_fill_width_p-1:0]    mem_rev_data_o,
  output logic                               mem_rev_v_o,
  input  logic                               mem_rev_ready_and_i,

  input  logic [addr_width_lp-1:0]           rd_addr_i,
  input  logic                               rd_v_i,
  output logic [bedrock_fill_width_p-1:0]    rd_data_o,
  output logic                               rd_v_o,

  output logic [31:0]                        wr_beats_o,
  output logic [15:0]                        bad_msgs_o
);

  localparam int fill_offset_lp = $clog2(bedrock_fill_width_p / 8);

  typedef enum logic [1:0] {
    eREADY  = 2'd0,
    eSTREAM = 2'd1,
    eRESP   = 2'd2
  } state_e;

  // Number of fill-width beats for a message of the given size code.
  function automatic logic [7:0] num_beats(logic [2:0] size);
    int msg_bits;
    msg_bits = 32'sd8 << size;
    if (msg_bits <= bedrock_fill_width_p) begin
      num_beats = 8'd1;
    end else begin
      num_beats = 8'(msg_bits / bedrock_fill_width_p);
    end
  endfunction

  state_e                 state_r, state_n;
  logic [7:0]             cnt_r, cnt_n;
  bp_bedrock_mem_header_s hdr_r, hdr_n;
  bp_bedrock_mem_header_s fwd_hdr;
  logic                   ready_r;
  logic                   rev_v_r;

  logic [2:0]                cur_size;
  bp_bedrock_mem_type_e      cur_type;
  logic [paddr_width_gp-1:0] cur_addr;
  logic [7:0]                cur_n;
  logic [7:0]                beat_idx;
  logic                      accept;
  logic                      is_uc_wr;
  logic                      wr_en;
  logic [addr_width_lp-1:0]  wr_addr;

  logic [bedrock_fill_width_p-1:0] mem [els_p];
  logic [bedrock_fill_width_p-1:0] rd_data_r;
  logic                            rd_v_r;

  assign fwd_hdr = mem_fwd_header_i;
  assign accept  = mem_fwd_v_i & ready_r;

  // Message attributes: the first beat uses the live header, later beats the latched copy.
  always_comb begin
    cur_size = hdr_r.size;
    cur_type = hdr_r.msg_type;
    cur_addr = hdr_r.addr;
    beat_idx = cnt_r;
    if (state_r == eREADY) begin
      cur_size = fwd_hdr.size;
      cur_type = fwd_hdr.msg_type;
      cur_addr = fwd_hdr.addr;
      beat_idx = 8'd0;
    end else begin
      cur_size = hdr_r.size;
      cur_type = hdr_r.msg_type;
      cur_addr = hdr_r.addr;
      beat_idx = cnt_r;
    end
  end

  assign cur_n    = num_beats(cur_size);
  assign is_uc_wr = (cur_type == e_bedrock_mem_uc_wr);
  assign wr_en    = accept & is_uc_wr;
  // Truncation to addr_width_lp implements the mod-els_p wrap.
  assign wr_addr  = addr_width_lp'(cur_addr >> fill_offset_lp) + addr_width_lp'(beat_idx);

  // Next-state, beat counter and header latch.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    hdr_n   = hdr_r;
    case (state_r)
      eREADY: begin
        if (accept) begin
          hdr_n = fwd_hdr;
          if (cur_n == 8'd1) begin
            state_n = eRESP;
            cnt_n   = 8'd0;
          end else begin
            state_n = eSTREAM;
            cnt_n   = 8'd1;
          end
        end else begin
          state_n = eREADY;
        end
      end
      eSTREAM: begin
        if (accept) begin
          if (cnt_r == (cur_n - 8'd1)) begin
            state_n = eRESP;
            cnt_n   = 8'd0;
          end else begin
            cnt_n = cnt_r + 8'd1;
          end
        end else begin
          state_n = eSTREAM;
        end
      end
      eRESP: begin
        if (mem_rev_ready_and_i) begin
          state_n = eREADY;
        end else begin
          state_n = eRESP;
        end
      end
      default: begin
        state_n = eREADY;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // State register; handshake outputs are registered copies of the next state.
  // ready_r stays 0 during reset, so the first edge after release raises it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eREADY;
      cnt_r   <= 8'd0;
      hdr_r   <= '0;
      ready_r <= 1'b0;
      rev_v_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      hdr_r   <= hdr_n;
      ready_r <= (state_n != eRESP);
      rev_v_r <= (state_n == eRESP);
    end
  end

  assign mem_fwd_ready_and_o = ready_r;
  assign mem_rev_v_o         = rev_v_r;
  assign mem_rev_header_o    = hdr_r;
  assign mem_rev_data_o      = '0;

  // Scratchpad write and synchronous read; nonblocking semantics give read-old-data on collision.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= mem_fwd_data_i;
    end
    if (rd_v_i) begin
      rd_data_r <= mem[rd_addr_i];
    end
  end

  // Read-valid pipeline stage.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_v_r <= 1'b0;
    end else begin
      rd_v_r <= rd_v_i;
    end
  end

  assign rd_data_o = rd_data_r;
  assign rd_v_o    = rd_v_r;

`ifdef BP_ME_ACCEL_WR_SINK_PERF_EN
  logic        bad_first;
  logic [31:0] wr_beats_r;
  logic [15:0] bad_msgs_r;

  // A rejected message is counted once, on its first beat.
  assign bad_first = accept & (state_r == eREADY) & ~is_uc_wr;

  // Saturating perf counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_beats_r <= 32'd0;
      bad_msgs_r <= 16'd0;
    end else begin
      if (wr_en && (wr_beats_r != 32'hFFFF_FFFF)) begin
        wr_beats_r <= wr_beats_r + 32'd1;
      end
      if (bad_first && (bad_msgs_r != 16'hFFFF)) begin
        bad_msgs_r <= bad_msgs_r + 16'd1;
      end
    end
  end

  assign wr_beats_o = wr_beats_r;
  assign bad_msgs_o = bad_msgs_r;
`else
  assign wr_beats_o = 32'd0;
  assign bad_msgs_o = 16'd0;
`endif

endmodule

// File: tb/tb_bp_me_accel_wr_sink.sv
// Self-checking bench for bp_me_accel_wr_sink: scenario tasks drive
// randomized traffic and compare against a word-array reference model.
module tb_bp_me_accel_wr_sink;
  import bp_me_accel_wr_sink_pkg::*;

  localparam int FILL = 64;
  localparam int ELS  = 256;
  localparam int HW   = $bits(bp_bedrock_mem_header_s);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [HW-1:0]   mem_fwd_header_i;
  logic [FILL-1:0] mem_fwd_data_i;
  logic            mem_fwd_v_i;
  logic            mem_fwd_ready_and_o;
  logic [HW-1:0]   mem_rev_header_o;
  logic [FILL-1:0] mem_rev_data_o;
  logic            mem_rev_v_o;
  logic            mem_rev_ready_and_i;
  logic [7:0]      rd_addr_i;
  logic            rd_v_i;
  logic [FILL-1:0] rd_data_o;
  logic            rd_v_o;
  logic [31:0]     wr_beats_o;
  logic [15:0]     bad_msgs_o;

  bp_me_accel_wr_sink #(.bp_params_p(e_bp_default_cfg), .els_p(ELS)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_fwd_header_i(mem_fwd_header_i), .mem_fwd_data_i(mem_fwd_data_i),
    .mem_fwd_v_i(mem_fwd_v_i), .mem_fwd_ready_and_o(mem_fwd_ready_and_o),
    .mem_rev_header_o(mem_rev_header_o), .mem_rev_data_o(mem_rev_data_o),
    .mem_rev_v_o(mem_rev_v_o), .mem_rev_ready_and_i(mem_rev_ready_and_i),
    .rd_addr_i(rd_addr_i), .rd_v_i(rd_v_i), .rd_data_o(rd_data_o), .rd_v_o(rd_v_o),
    .wr_beats_o(wr_beats_o), .bad_msgs_o(bad_msgs_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: scratchpad words, which words are known, and event counts.
  logic [FILL-1:0] model_mem [ELS];
  bit              model_vld [ELS];
  int unsigned     exp_wr_beats;
  int unsigned     exp_bad;
  logic [FILL-1:0] beat_data [16];

  function automatic logic [31:0] port_wr_beats();
`ifdef BP_ME_ACCEL_WR_SINK_PERF_EN
    return exp_wr_beats;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [15:0] port_bad_msgs();
`ifdef BP_ME_ACCEL_WR_SINK_PERF_EN
    return 16'(exp_bad);
`else
    return 16'd0;
`endif
  endfunction

  function automatic int beats_for(input logic [2:0] sz);
    int bits;
    bits = 8 << sz;
    return (bits < FILL) ? 1 : bits / FILL;
  endfunction

  task automatic check_counters(input string tag);
    n_cmp++;
    if (wr_beats_o !== port_wr_beats() || bad_msgs_o !== port_bad_msgs()) begin
      n_err++;
      $display("FAIL %s_counters: wr_beats=%0d bad=%0d required wr_beats=%0d bad=%0d",
               tag, wr_beats_o, bad_msgs_o, port_wr_beats(), port_bad_msgs());
    end
  endtask

  // Stream one message, then take its response after `stall` cycles of back-pressure.
  task automatic send_msg(input logic [3:0] mtype, input logic [2:0] sz, input logic [39:0] addr,
                          input int stall, input bit gaps, input bit rand_data);
    bp_bedrock_mem_header_s h;
    int n, k, cyc, w;
    h.msg_type = bp_bedrock_mem_type_e'(mtype);
    h.size     = sz;
    h.addr     = addr;
    h.subop    = 4'($urandom);
    h.payload  = 16'($urandom);
    n = beats_for(sz);
    if (rand_data) for (int i = 0; i < n; i++) beat_data[i] = {$urandom, $urandom};
    k = 0;
    cyc = 0;
    while (k < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      mem_fwd_header_i = h;
      mem_fwd_data_i   = beat_data[k];
      mem_fwd_v_i      = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      n_cmp++;
      if (mem_fwd_ready_and_o !== 1'b1 || mem_rev_v_o !== 1'b0) begin
        n_err++;
        $display("FAIL stream_hs: ready=%b rev_v=%b required ready=1 rev_v=0 (beat %0d)",
                 mem_fwd_ready_and_o, mem_rev_v_o, k);
      end
      if (mem_fwd_v_i) k++;
    end
    n_cmp++;
    if (k != n) begin
      n_err++;
      $display("FAIL stream_timeout: accepted %0d beats required %0d", k, n);
    end
    @(negedge clk);
    mem_fwd_v_i = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) @(negedge clk);
      n_cmp++;
      if (mem_rev_v_o !== 1'b1 || mem_rev_header_o !== h || mem_rev_data_o !== '0 ||
          mem_fwd_ready_and_o !== 1'b0) begin
        n_err++;
        $display("FAIL resp: v=%b hdr=%h data=%h fwd_ready=%b required v=1 hdr=%h data=0 fwd_ready=0",
                 mem_rev_v_o, mem_rev_header_o, mem_rev_data_o, mem_fwd_ready_and_o, h);
      end
      mem_rev_ready_and_i = (s == stall);
      // Offer stray beats while the response is pending; none may be taken.
      mem_fwd_v_i    = 1'($urandom_range(0, 1));
      mem_fwd_data_i = {$urandom, $urandom};
    end
    @(negedge clk);
    mem_rev_ready_and_i = 1'b0;
    mem_fwd_v_i         = 1'b0;
    if (mtype == 4'(e_bedrock_mem_uc_wr)) begin
      for (int i = 0; i < n; i++) begin
        w = (int'(addr >> 3) + i) % ELS;
        model_mem[w] = beat_data[i];
        model_vld[w] = 1'b1;
      end
      exp_wr_beats += n;
    end else begin
      exp_bad++;
    end
    n_cmp++;
    if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b1) begin
      n_err++;
      $display("FAIL resp_done: rev_v=%b fwd_ready=%b required rev_v=0 fwd_ready=1",
               mem_rev_v_o, mem_fwd_ready_and_o);
    end
    check_counters("msg");
  endtask

  // Read one word; check data next cycle and that it holds once rd_v_o drops.
  task automatic read_check(input int addr);
    @(negedge clk);
    rd_addr_i = 8'(addr);
    rd_v_i    = 1'b1;
    @(negedge clk);
    rd_v_i    = 1'b0;
    rd_addr_i = 8'($urandom);
    n_cmp++;
    if (rd_v_o !== 1'b1 || (model_vld[addr] && rd_data_o !== model_mem[addr])) begin
      n_err++;
      $display("FAIL read[%0d]: v=%b data=%h required v=1 data=%h", addr, rd_v_o, rd_data_o, model_mem[addr]);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_v_o !== 1'b0 || (model_vld[addr] && rd_data_o !== model_mem[addr])) begin
      n_err++;
      $display("FAIL read_hold[%0d]: v=%b data=%h required v=0 data=%h", addr, rd_v_o, rd_data_o, model_mem[addr]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_fwd_header_i = '0; mem_fwd_data_i = '0; mem_fwd_v_i = 1'b0;
    mem_rev_ready_and_i = 1'b0; rd_addr_i = 8'd0; rd_v_i = 1'b0;
    exp_wr_beats = 0; exp_bad = 0;
    for (int i = 0; i < ELS; i++) model_vld[i] = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b0 || rd_v_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: rev_v=%b fwd_ready=%b rd_v=%b required 0 0 0",
               mem_rev_v_o, mem_fwd_ready_and_o, rd_v_o);
    end
    check_counters("reset");
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (mem_fwd_ready_and_o !== 1'b0) begin
      n_err++;
      $display("FAIL release_ready_early: ready=%b required 0", mem_fwd_ready_and_o);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_fwd_ready_and_o !== 1'b1 || mem_rev_v_o !== 1'b0) begin
      n_err++;
      $display("FAIL release_ready: ready=%b rev_v=%b required 1 0", mem_fwd_ready_and_o, mem_rev_v_o);
    end
  endtask

  task automatic test_uc_wr_64b();
    for (int i = 0; i < 8; i++) beat_data[i] = 64'(i + 1);
    send_msg(4'(e_bedrock_mem_uc_wr), 3'd6, 40'h80, 0, 1'b0, 1'b0);
    for (int w = 16; w < 24; w++) read_check(w);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) beat_data[i] = {$urandom, $urandom};
    send_msg(4'(e_bedrock_mem_uc_wr), 3'd6, 40'h80, 5, 1'b0, 1'b0);
    read_check(16);
    read_check(23);
  endtask

  task automatic test_wrap();
    send_msg(4'(e_bedrock_mem_uc_wr), 3'd5, 40'(254 * 8), 1, 1'b1, 1'b1);
    read_check(254);
    read_check(255);
    read_check(0);
    read_check(1);
  endtask

  task automatic test_bad_msg();
    send_msg(4'(e_bedrock_mem_uc_rd), 3'd4, 40'h80, 2, 1'b0, 1'b1);
    read_check(16);
    read_check(17);
  endtask

  task automatic test_rd_wr_collision();
    bp_bedrock_mem_header_s h;
    beat_data[0] = 64'h11;
    send_msg(4'(e_bedrock_mem_uc_wr), 3'd3, 40'h28, 0, 1'b0, 1'b0);
    h = '{payload: 16'h0, size: 3'd3, addr: 40'h28, subop: 4'h0, msg_type: e_bedrock_mem_uc_wr};
    @(negedge clk);
    mem_fwd_header_i = h; mem_fwd_data_i = 64'hAA; mem_fwd_v_i = 1'b1;
    rd_addr_i = 8'd5; rd_v_i = 1'b1;
    @(negedge clk);
    mem_fwd_v_i = 1'b0; rd_v_i = 1'b0;
    n_cmp++;
    if (rd_v_o !== 1'b1 || rd_data_o !== 64'h11 || mem_rev_v_o !== 1'b1) begin
      n_err++;
      $display("FAIL collision_old: rd_v=%b data=%h rev_v=%b required 1 0x11 1", rd_v_o, rd_data_o, mem_rev_v_o);
    end
    mem_rev_ready_and_i = 1'b1;
    @(negedge clk);
    mem_rev_ready_and_i = 1'b0;
    model_mem[5] = 64'hAA;
    exp_wr_beats += 1;
    read_check(5);
    check_counters("collision");
  endtask

  task automatic test_reset_midstream();
    bp_bedrock_mem_header_s h;
    h = '{payload: 16'h1234, size: 3'd6, addr: 40'h400, subop: 4'h3, msg_type: e_bedrock_mem_uc_wr};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      beat_data[i] = {$urandom, $urandom};
      mem_fwd_header_i = h; mem_fwd_data_i = beat_data[i]; mem_fwd_v_i = 1'b1;
    end
    @(negedge clk);
    mem_fwd_v_i = 1'b0;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      model_mem[128 + i] = beat_data[i];
      model_vld[128 + i] = 1'b1;
    end
    exp_wr_beats = 0;
    exp_bad = 0;
    n_cmp++;
    if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b0 || rd_v_o !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: rev_v=%b fwd_ready=%b rd_v=%b required 0 0 0",
               mem_rev_v_o, mem_fwd_ready_and_o, rd_v_o);
    end
    check_counters("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_rev_v_o !== 1'b0 || mem_fwd_ready_and_o !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_release: rev_v=%b fwd_ready=%b required 0 1", mem_rev_v_o, mem_fwd_ready_and_o);
    end
    for (int i = 0; i < 3; i++) read_check(128 + i);
    send_msg(4'(e_bedrock_mem_uc_wr), 3'd6, 40'h400, 1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) read_check(128 + i);
  endtask

  task automatic test_random();
    logic [3:0] mt;
    for (int m = 0; m < 25; m++) begin
      case ($urandom_range(0, 9))
        0:       mt = 4'(e_bedrock_mem_uc_rd);
        1:       mt = 4'(e_bedrock_mem_wr);
        2:       mt = 4'(e_bedrock_mem_amo);
        default: mt = 4'(e_bedrock_mem_uc_wr);
      endcase
      send_msg(mt, 3'($urandom_range(0, 6)), {8'($urandom), 32'($urandom)},
               int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end
    for (int w = 0; w < ELS; w++) if (model_vld[w]) read_check(w);
  endtask

  initial begin
    test_reset();
    test_uc_wr_64b();
    test_backpressure();
    test_wrap();
    test_bad_msg();
    test_rd_wr_collision();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
